ifm_in_fsm: RTL and testbench

IFM_IN_FSM -- requirements
Module: ifm_in_fsm

---
 rtl/ifm_in_fsm_if.sv | 32 +++
 rtl/ifm_in_fsm.sv | 125 ++++++++++++
 tb/tb_ifm_in_fsm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ifm_in_fsm_if.sv
// Bundles the MAC receive side, both FIFO write ports and the frame counters.
// No storage or latency of its own; it only carries wires.
// FIFO flow control is carried by data_fifo_afull and info_fifo_full.
interface ifm_in_fsm_if;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_good_frame;
    logic        rx_bad_frame;
    logic [72:0] data_fifo_wdata;
    logic        data_fifo_wren;
    logic        data_fifo_afull;
    logic        info_fifo_wdata;
    logic        info_fifo_wren;
    logic        info_fifo_full;
    logic [31:0] stat_good_cnt;
    logic [31:0] stat_bad_cnt;
    logic [31:0] stat_drop_cnt;

    modport slave (
        input  rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
        input  data_fifo_afull, info_fifo_full,
        output data_fifo_wdata, data_fifo_wren, info_fifo_wdata, info_fifo_wren,
        output stat_good_cnt, stat_bad_cnt, stat_drop_cnt
    );

    modport master (
        output rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
        output data_fifo_afull, info_fifo_full,
        input  data_fifo_wdata, data_fifo_wren, info_fifo_wdata, info_fifo_wren,
        input  stat_good_cnt, stat_bad_cnt, stat_drop_cnt
    );
endinterface

// File: rtl/ifm_in_fsm.sv
// Converts the MAC receive stream into data-FIFO words plus one good/bad word per frame.
// A beat reaches the data FIFO two cycles after it is sampled; a status pulse reaches the info FIFO one cycle later.
// FIFO space is checked only at SOF; a frame that starts without room is dropped whole.
module ifm_in_fsm #(
    parameter int C_MAX_BEATS = 1152
) (
    input  logic   rx_clk,
    input  logic   rx_reset_n,
    ifm_in_fsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, STATUS, DROP} state_t;

    localparam logic [15:0] MAX_BEATS = 16'(C_MAX_BEATS);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [63:0] hold_dat_q;
    logic [7:0]  hold_keep_q;
    logic        gap_seen_q;
    logic [72:0] dwdata_q;
    logic        dwren_q;
    logic        iwdata_q;
    logic        iwren_q;
    logic [31:0] good_cnt_q;
    logic [31:0] bad_cnt_q;
    logic [31:0] drop_cnt_q;

    logic beat, status, frame_ok, oversize, drop_exit, sof, info_we, info_v;

    // Decode this cycle's events. A status pulse coincident with the next
    // frame's first beat (from STATUS or when leaving DROP) also starts that frame.
    always_comb begin
        beat      = |bus.rx_data_valid;
        status    = bus.rx_good_frame | bus.rx_bad_frame;
        frame_ok  = bus.rx_good_frame & ~bus.rx_bad_frame;
        oversize  = (state_q == DATA) && beat && (cnt_q == MAX_BEATS);
        drop_exit = (state_q == DROP) && status && (!beat || gap_seen_q);
        sof       = beat && ((state_q == IDLE) || ((state_q == STATUS) && status) || drop_exit);
        info_we   = oversize || ((state_q == DATA) && !beat && status) ||
                    ((state_q == STATUS) && status);
        info_v    = oversize ? 1'b0 : frame_ok;
    end

    // Frame FSM with the hold register, registered FIFO writes and counters.
    always_ff @(posedge rx_clk) begin
        if (!rx_reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_dat_q  <= '0;
            hold_keep_q <= '0;
            gap_seen_q  <= 1'b0;
            dwdata_q    <= '0;
            dwren_q     <= 1'b0;
            iwdata_q    <= 1'b0;
            iwren_q     <= 1'b0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            dwren_q <= 1'b0;
            iwren_q <= 1'b0;

            case (state_q)
                DATA: begin
                    dwren_q <= 1'b1;
                    if (beat) begin
                        if (oversize) begin
                            // Truncate: close the frame on the held word, discard the rest.
                            dwdata_q   <= {1'b1, hold_keep_q, hold_dat_q};
                            state_q    <= DROP;
                            gap_seen_q <= 1'b0;
                        end else begin
                            dwdata_q    <= {1'b0, hold_keep_q, hold_dat_q};
                            hold_dat_q  <= bus.rx_data;
                            hold_keep_q <= bus.rx_data_valid;
                            cnt_q       <= cnt_q + 16'd1;
                        end
                    end else begin
                        dwdata_q <= {1'b1, hold_keep_q, hold_dat_q};
                        state_q  <= status ? IDLE : STATUS;
                    end
                end
                STATUS: begin
                    if (status) state_q <= IDLE;
                end
                DROP: begin
                    if (!beat) gap_seen_q <= 1'b1;
                    if (drop_exit) state_q <= IDLE;
                end
                default: ;
            endcase

            if (info_we) begin
                iwren_q  <= 1'b1;
                iwdata_q <= info_v;
                if (info_v) begin
                    if (good_cnt_q != '1) good_cnt_q <= good_cnt_q + 32'd1;
                end else begin
                    if (bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 32'd1;
                end
            end

            if (sof) begin
                if (!bus.data_fifo_afull && !bus.info_fifo_full) begin
                    hold_dat_q  <= bus.rx_data;
                    hold_keep_q <= bus.rx_data_valid;
                    cnt_q       <= 16'd1;
                    state_q     <= DATA;
                end else begin
                    if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
                    gap_seen_q <= 1'b0;
                    state_q    <= DROP;
                end
            end
        end
    end

    assign bus.data_fifo_wdata = dwdata_q;
    assign bus.data_fifo_wren  = dwren_q;
    assign bus.info_fifo_wdata = iwdata_q;
    assign bus.info_fifo_wren  = iwren_q;
    assign bus.stat_good_cnt   = good_cnt_q;
    assign bus.stat_bad_cnt    = bad_cnt_q;
    assign bus.stat_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_ifm_in_fsm.sv
// Scoreboard bench: stimulus pushes expected FIFO words with their due cycle,
// a negedge monitor pops and compares whenever a write strobe is seen.
module tb_ifm_in_fsm;
    localparam int MAXB = 4;

    typedef struct {
        logic [72:0] d;
        int          c;
    } dexp_t;
    typedef struct {
        logic v;
        int   c;
    } iexp_t;

    logic rx_clk = 1'b0;
    logic rx_reset_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   exp_good = 0, exp_bad = 0, exp_drop = 0;
    dexp_t dq[$];
    iexp_t iq[$];
    dexp_t mon_d;
    iexp_t mon_i;

    ifm_in_fsm_if bus ();

    ifm_in_fsm #(.C_MAX_BEATS(MAXB)) dut (
        .rx_clk     (rx_clk),
        .rx_reset_n (rx_reset_n),
        .bus        (bus)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] v, input logic g, input logic b);
        @(posedge rx_clk);
        #1;
        bus.rx_data       = d;
        bus.rx_data_valid = v;
        bus.rx_good_frame = g;
        bus.rx_bad_frame  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push_d(input logic eof, input logic [7:0] k, input logic [63:0] d, input int c);
        dexp_t e;
        e.d = {eof, k, d};
        e.c = c;
        dq.push_back(e);
    endtask

    task automatic push_i(input logic v, input int c);
        iexp_t e;
        e.v = v;
        e.c = c;
        iq.push_back(e);
    endtask

    // One frame of n beats, dly gap cycles before the status pulse.
    task automatic frame(input logic [31:0] tag, input int n, input logic [7:0] last_keep,
                         input int dly, input logic g, input logic b, input bit acc);
        logic [63:0] d;
        logic [7:0]  k;
        bit          over;
        over = (n > MAXB);
        for (int i = 0; i < n; i++) begin
            d = {tag, 32'(i)};
            k = (i == n - 1) ? last_keep : 8'hFF;
            drive(d, k, 1'b0, 1'b0);
            if (acc && i < MAXB) push_d((i == n - 1) || (i == MAXB - 1), k, d, cyc + 2);
            if (acc && over && i == MAXB) push_i(1'b0, cyc + 1);
        end
        idle(dly);
        drive(64'h0, 8'h00, g, b);
        if (acc && !over) push_i(g & ~b, cyc + 1);
        idle(1);
        if (!acc) exp_drop++;
        else if (over || !(g & ~b)) exp_bad++;
        else exp_good++;
    endtask

    task automatic chk_stats(input string tag);
        idle(3);
        chk({tag, "_good_cnt"}, 73'(bus.stat_good_cnt), 73'(exp_good));
        chk({tag, "_bad_cnt"},  73'(bus.stat_bad_cnt),  73'(exp_bad));
        chk({tag, "_drop_cnt"}, 73'(bus.stat_drop_cnt), 73'(exp_drop));
    endtask

    // Monitor: every write strobe must match the next expected entry and its cycle.
    always @(negedge rx_clk) begin
        if (bus.data_fifo_wren === 1'b1) begin
            if (dq.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL data_unexpected: got %h expected no write (cycle %0d)", bus.data_fifo_wdata, cyc);
            end else begin
                mon_d = dq.pop_front();
                chk("data_word", bus.data_fifo_wdata, mon_d.d);
                chk("data_cycle", 73'(cyc), 73'(mon_d.c));
            end
        end
        if (bus.info_fifo_wren === 1'b1) begin
            if (iq.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL info_unexpected: got %b expected no write (cycle %0d)", bus.info_fifo_wdata, cyc);
            end else begin
                mon_i = iq.pop_front();
                chk("info_word", 73'(bus.info_fifo_wdata), 73'(mon_i.v));
                chk("info_cycle", 73'(cyc), 73'(mon_i.c));
            end
        end
    end

    initial begin
        bus.rx_data = '0;
        bus.rx_data_valid = '0;
        bus.rx_good_frame = 1'b0;
        bus.rx_bad_frame = 1'b0;
        bus.data_fifo_afull = 1'b0;
        bus.info_fifo_full = 1'b0;
        idle(3);
        chk("rst_data_wren", 73'(bus.data_fifo_wren), 73'(0));
        chk("rst_info_wren", 73'(bus.info_fifo_wren), 73'(0));
        chk("rst_data_wdata", bus.data_fifo_wdata, 73'(0));
        chk("rst_info_wdata", 73'(bus.info_fifo_wdata), 73'(0));
        chk_stats("rst");
        rx_reset_n = 1'b1;
        idle(2);

        // 3-beat good frame, status in the gap cycle.
        frame(32'hA000_0001, 3, 8'h0F, 0, 1'b1, 1'b0, 1'b1);
        chk_stats("three_beat");
        // 1-beat bad frame, status four cycles after the gap.
        frame(32'hA000_0002, 1, 8'h3F, 4, 1'b0, 1'b1, 1'b1);
        chk_stats("late_bad");
        // Data FIFO almost full at SOF: whole frame dropped, next one accepted.
        bus.data_fifo_afull = 1'b1;
        frame(32'hA000_0003, 5, 8'hFF, 0, 1'b1, 1'b0, 1'b0);
        bus.data_fifo_afull = 1'b0;
        frame(32'hA000_0004, 2, 8'h01, 0, 1'b1, 1'b0, 1'b1);
        chk_stats("afull_drop");
        // Info FIFO full at SOF: dropped, exit only once status follows a gap.
        bus.info_fifo_full = 1'b1;
        frame(32'hA000_0005, 2, 8'hFF, 2, 1'b0, 1'b1, 1'b0);
        bus.info_fifo_full = 1'b0;
        // Both status bits high counts as bad.
        frame(32'hA000_0006, 2, 8'hFF, 1, 1'b1, 1'b1, 1'b1);
        chk_stats("full_and_both");
        // Oversize frame truncated at MAXB beats, then a normal frame.
        frame(32'hA000_0007, 6, 8'hFF, 0, 1'b1, 1'b0, 1'b1);
        frame(32'hA000_0008, 1, 8'h80, 0, 1'b1, 1'b0, 1'b1);
        chk_stats("oversize");

        // Back-to-back: A's status pulse lands with B's first beat.
        drive(64'hAAAA_0000_0000_0000, 8'hFF, 1'b0, 1'b0);
        push_d(1'b0, 8'hFF, 64'hAAAA_0000_0000_0000, cyc + 2);
        drive(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        push_d(1'b1, 8'hFF, 64'hAAAA_0000_0000_0001, cyc + 2);
        idle(1);
        drive(64'hBBBB_0000_0000_0000, 8'hFF, 1'b1, 1'b0);
        push_i(1'b1, cyc + 1);
        push_d(1'b0, 8'hFF, 64'hBBBB_0000_0000_0000, cyc + 2);
        drive(64'hBBBB_0000_0000_0001, 8'h07, 1'b0, 1'b0);
        push_d(1'b1, 8'h07, 64'hBBBB_0000_0000_0001, cyc + 2);
        drive(64'h0, 8'h00, 1'b1, 1'b0);
        push_i(1'b1, cyc + 1);
        exp_good += 2;
        chk_stats("back_to_back");

        // Reset during beat 2 of 4: frame abandoned, counters cleared.
        drive(64'hCCCC_0000_0000_0000, 8'hFF, 1'b0, 1'b0);
        @(posedge rx_clk);
        #1;
        rx_reset_n = 1'b0;
        bus.rx_data = 64'hCCCC_0000_0000_0001;
        bus.rx_data_valid = 8'hFF;
        @(posedge rx_clk);
        #1;
        rx_reset_n = 1'b1;
        bus.rx_data = '0;
        bus.rx_data_valid = '0;
        idle(2);
        drive(64'h0, 8'h00, 1'b1, 1'b0);
        exp_good = 0;
        exp_bad = 0;
        exp_drop = 0;
        chk_stats("mid_reset");
        frame(32'hA000_0009, 4, 8'h1F, 0, 1'b1, 1'b0, 1'b1);
        chk_stats("after_reset");

        idle(5);
        chk("data_queue_drained", 73'(dq.size()), 73'(0));
        chk("info_queue_drained", 73'(iq.size()), 73'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
